// File: rtl/max_sel18_seq_pkg.sv
// Shared definitions for the sequential max-element selector.
package max_sel18_seq_pkg;

    localparam int N  = 18;  // unit elements
    localparam int W  = 7;   // element width, signed
    localparam int CW = 5;   // count width
    localparam int IW = 5;   // index width, $clog2(N)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Clamp a requested count to the number of available elements.
    function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] c,
                                                input logic [CW-1:0] lim);
        return (c > lim) ? lim : c;
    endfunction

endpackage

// File: rtl/max_sel18_seq_argmax18_idx.sv
// Combinational argmax over the valid subset of N signed elements.
// Pairwise tree carrying (value, index, valid); the left operand always
// holds the lower indices, so it wins on equal values.
module argmax18_idx
    import max_sel18_seq_pkg::*;
#(
    parameter int N = max_sel18_seq_pkg::N,
    parameter int W = max_sel18_seq_pkg::W
) (
    input  logic [N*W-1:0] a,
    input  logic [N-1:0]   vld,
    output logic [IW-1:0]  idx,
    output logic           any
);

    // Leaves are padded to 32 with invalid entries; the tree is 5 levels.
    logic signed [W-1:0] val [0:5][0:31];
    logic [IW-1:0]       ix  [0:5][0:31];
    logic                ok  [0:5][0:31];

    // Reduce the padded leaf set level by level down to a single winner.
    always_comb begin
        for (int unsigned l = 0; l < 6; l++) begin
            for (int unsigned i = 0; i < 32; i++) begin
                val[l][i] = '0;
                ix[l][i]  = '0;
                ok[l][i]  = 1'b0;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            val[0][i] = a[i*W +: W];
            ix[0][i]  = IW'(i);
            ok[0][i]  = vld[i];
        end
        for (int unsigned l = 0; l < 5; l++) begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (ok[l][2*i] && (!ok[l][2*i+1] || (val[l][2*i] >= val[l][2*i+1]))) begin
                    val[l+1][i] = val[l][2*i];
                    ix[l+1][i]  = ix[l][2*i];
                    ok[l+1][i]  = 1'b1;
                end else begin
                    val[l+1][i] = val[l][2*i+1];
                    ix[l+1][i]  = ix[l][2*i+1];
                    ok[l+1][i]  = ok[l][2*i+1];
                end
            end
        end
        idx = ix[5][0];
        any = ok[5][0];
    end

endmodule

// File: rtl/max_sel18_seq.sv
// Sequential selector: picks the k largest of N latched signed elements,
// one per cycle, and presents them as a unit-element enable vector.
module max_sel18_seq
    import max_sel18_seq_pkg::*;
#(
    parameter int N  = max_sel18_seq_pkg::N,
    parameter int W  = max_sel18_seq_pkg::W,
    parameter int CW = max_sel18_seq_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] count,
    input  logic [N*W-1:0] a,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  sel
);

    state_t         state;
    logic [N*W-1:0] vec;
    logic [N-1:0]   mask;
    logic [N-1:0]   work;
    logic [CW-1:0]  rem;
    logic [CW-1:0]  k_sat;
    logic [IW-1:0]  pick_idx;
    logic           pick_any;
    logic [N-1:0]   pick;

    argmax18_idx #(
        .N(N),
        .W(W)
    ) u_argmax (
        .a   (vec),
        .vld (~mask),
        .idx (pick_idx),
        .any (pick_any)
    );

    // One-hot of the element chosen this cycle and the clamped request size.
    always_comb begin
        pick  = pick_any ? ({{(N-1){1'b0}}, 1'b1} << pick_idx) : '0;
        k_sat = sat_count(count, CW'(N));
    end

    // Busy reflects the scanning phase only.
    always_comb begin
        busy = (state == SCAN);
    end

    // FSM, operand latch, mask/selection update and output register.
    // sel is loaded on the edge that enters DONE; done follows one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            vec   <= '0;
            mask  <= '0;
            work  <= '0;
            rem   <= '0;
            sel   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        vec  <= a;
                        rem  <= k_sat;
                        mask <= '0;
                        work <= '0;
                        if (k_sat == '0) begin
                            sel   <= '0;
                            state <= DONE;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    mask <= mask | pick;
                    work <= work | pick;
                    rem  <= rem - 1'b1;
                    if (rem == CW'(1)) begin
                        sel   <= work | pick;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_max_sel18_seq.sv
// Self-checking bench for max_sel18_seq with a rank-based reference model.
module tb_max_sel18_seq;

    localparam int N  = 18;
    localparam int W  = 7;
    localparam int CW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [CW-1:0]  count;
    logic [N*W-1:0] a;
    logic           busy;
    logic           done;
    logic [N-1:0]   sel;

    int checks = 0;
    int errors = 0;

    max_sel18_seq #(
        .N (N),
        .W (W),
        .CW(CW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .count(count),
        .a    (a),
        .busy (busy),
        .done (done),
        .sel  (sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Element i is selected when fewer than k elements outrank it
    // (strictly larger, or equal with a lower index).
    function automatic logic [N-1:0] model(input logic [N*W-1:0] av, input int k);
        int v[N];
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) v[i] = int'($signed(av[i*W +: W]));
        for (int i = 0; i < N; i++) begin
            int beats;
            beats = 0;
            for (int j = 0; j < N; j++)
                if (v[j] > v[i] || (v[j] == v[i] && j < i)) beats++;
            r[i] = (beats < k);
        end
        return r;
    endfunction

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0:       r[i*W +: W] = 7'h40;
                1:       r[i*W +: W] = 7'h3F;
                2:       r[i*W +: W] = 7'($urandom_range(0, 3));
                default: r[i*W +: W] = 7'($urandom);
            endcase
        end
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [N*W-1:0] av, input logic [CW-1:0] cnt,
                          input logic [N-1:0] lit, input bit use_lit, input bit extra_start);
        int k;
        int n;
        int bcnt;
        bit seen;
        bit overlap;
        logic [N-1:0] exp_sel;
        k       = (int'(cnt) > N) ? N : int'(cnt);
        exp_sel = model(av, k);
        a       = av;
        count   = cnt;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        seen    = 1'b0;
        overlap = 1'b0;
        bcnt    = 0;
        for (n = 1; n <= 40; n++) begin
            a     = rand_vec();
            count = CW'($urandom);
            if (busy) bcnt++;
            if (busy && done) overlap = 1'b1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = (extra_start && n == 2);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(k + 2));
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(k));
        chk({tag, "_busy_done_excl"}, 32'(overlap), 32'd0);
        chk({tag, "_sel"}, 32'(sel), 32'(exp_sel));
        if (use_lit) chk({tag, "_sel_lit"}, 32'(sel), 32'(lit));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_sel_hold"}, 32'(sel), 32'(exp_sel));
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [N*W-1:0] v;
        bit flag;

        rst   = 1'b1;
        start = 1'b0;
        count = '0;
        a     = '0;
        repeat (2) @(negedge clk);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // rst and start together: nothing must start
        for (int i = 0; i < N; i++) v[i*W +: W] = 7'(i - 9);
        a     = v;
        count = 5'd3;
        start = 1'b1;
        @(negedge clk);
        chk("rst_start_busy", 32'(busy), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        flag  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy || done) flag = 1'b1;
        end
        chk("rst_start_no_op", 32'(flag), 32'd0);

        // ramp, k=3
        run_op("ramp_k3", v, 5'd3, 18'h38000, 1'b1, 1'b0);

        // all equal, lowest-index tie-break
        for (int i = 0; i < N; i++) v[i*W +: W] = 7'd5;
        run_op("eq5_k4", v, 5'd4, 18'h0000F, 1'b1, 1'b0);

        // -64 is a legal value, selected last with k=18 and saturated count
        for (int i = 0; i < N; i++) v[i*W +: W] = 7'h3F;
        v[7*W +: W] = 7'h40;
        run_op("neg64_k18", v, 5'd18, 18'h3FFFF, 1'b1, 1'b0);
        run_op("neg64_k25", v, 5'd25, 18'h3FFFF, 1'b1, 1'b0);
        run_op("neg64_k17", v, 5'd17, 18'h3FF7F, 1'b1, 1'b0);

        // k=0
        run_op("k0", rand_vec(), 5'd0, 18'h0, 1'b1, 1'b0);

        // extra start during SCAN is ignored
        run_op("k5_extra", rand_vec(), 5'd5, 18'h0, 1'b0, 1'b1);
        flag = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy || done) flag = 1'b1;
        end
        chk("k5_extra_no_queue", 32'(flag), 32'd0);

        // reset on the second SCAN cycle of a k=6 request
        a     = rand_vec();
        count = 5'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sel", 32'(sel), 32'd0);
        rst  = 1'b0;
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) flag = 1'b1;
        end
        chk("mid_rst_no_done", 32'(flag), 32'd0);
        run_op("after_rst_k2", rand_vec(), 5'd2, 18'h0, 1'b0, 1'b0);

        // randomized requests
        for (int t = 0; t < 25; t++) begin
            run_op($sformatf("rnd%0d", t), rand_vec(), CW'($urandom_range(0, 24)), 18'h0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/max_sel18_seq.md
# max_sel18_seq

Sequential element selector for the DAC mismatch-shaping path. It latches an 18-element signed 7-bit state vector and a requested element count k, and iteratively picks the k largest elements, one per cycle. The result is an 18-bit unit-element enable vector. It is the max-side, select-producing counterpart of the combinational 18-element MIN normaliser, and sits between the state-vector update and the unit-element DAC drivers.

## Interface
- `N`, 18, number of unit elements.
- `W`, 7, element width (signed two's complement).
- `CW`, 5, count width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `count`  in  CW  number of elements to select (unsigned).
- `a`  in  N*W  packed vector; element i = `a[i*W +: W]`, signed.
- `busy`  out  1  high in SCAN.
- `done`  out  1  one-cycle pulse when `sel` is final.
- `sel`  out  N  selection vector; bit i = element i enabled.

## Operation
- States:
  - IDLE -> SCAN on `start`.
  - SCAN -> DONE when remaining reaches 0.
  - DONE -> IDLE unconditionally.
- On `start` in IDLE:
  - latch `a` into an internal vector register;
  - latch remaining = min(`count`, N); `count` > 18 saturates to 18;
  - clear the internal mask and the working selection.
- Each SCAN cycle:
  - A combinational argmax over unmasked elements returns the index j.
  - Set mask[j] and selection bit j; decrement remaining.
  - If the new remaining is 0, go to DONE.
- Compare rules:
  - Signed comparison across the full range −64..+63.
  - Masked elements are excluded by a valid flag, never by substituting −64, because −64 is a legal value.
  - Ties resolve to the lowest index.
- k = 0: SCAN is skipped; IDLE -> DONE directly, with `sel` = 0.
- `sel` output register:
  - loaded from the working selection on entry to DONE;
  - held until the next DONE or reset.
- `start` while in SCAN or DONE is ignored; there is no queueing.
- Changes on `a` and `count` after the `start` edge have no effect on the current operation.

## Timing
- Reset values: `busy`=0, `done`=0, `sel`=0, state=IDLE; mask, working selection and remaining are cleared.
- Latency: with `start` sampled at edge T, `done` is high in the cycle after edge T+max(k,0)+1.
  - k=0: `done` high after edge T+1.
  - k=18: `done` high after edge T+19.
- `busy` is high for exactly k cycles and is never high together with `done`.
- Throughput: the next `start` is accepted in the cycle after `done`, i.e. one request per k+2 cycles.
- Reset asserted mid-SCAN or in DONE:
  - next edge returns all outputs to reset values;
  - the partial selection is discarded and no `done` is issued.
- `rst` and `start` in the same cycle: reset wins.
- Critical path: the 18-input argmax tree, depth 5, followed by mask/selection update. It must close in one cycle at DAC clock rate. No internal pipelining.

## Structure
- Shared package holds:
  - `N`, `W`, `CW` defaults;
  - the state enum {IDLE, SCAN, DONE};
  - a function for saturating `count` to N.
- One sub-module: `argmax18_idx`, purely combinational.
  - Inputs: N signed W-bit values plus an N-bit valid mask.
  - Outputs: 5-bit index and any-valid flag.
  - Built as a pairwise tree carrying (value, index, valid); on equal values the lower index wins.
- The top holds the FSM, latched vector, mask, remaining counter and output register.

## Test plan
- Reset, then idle: `sel`=0, `busy`=0, `done`=0. Assert `start` with `rst` in the same cycle -> no operation starts.
- a[i]=i−9 (i=0..17), k=3 -> `done` 4 cycles after `start`; `sel`=18'h38000 (elements 15, 16, 17).
- All elements equal to +5, k=4 -> `sel`=18'h0000F (lowest-index tie-break).
- Only a[7]=−64, all others +63, k=18 -> `sel`=18'h3FFFF with `done` at cycle 19. With `count`=25 instead, the result is identical (saturation).
- k=0 -> `done` one cycle after `start`, `sel`=0, `busy` never high. A second `start` pulsed during a k=5 SCAN is ignored; the `sel` of the first request is unchanged.
- `rst` asserted on the 2nd SCAN cycle of a k=6 request -> next cycle all outputs are 0 and no `done` pulse. A fresh k=2 request then completes normally.
